// File: rtl/signal_switch_n_if.sv
// Stream and control bundle for the N-channel signal switch.
// The master side drives the samples and the channel requests. The slave side
// (the switch) drives back the routed sample and the status flags.
interface signal_switch_n_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int CHANNEL_COUNT = 4,
  parameter int SEL_WIDTH     = 2
) ();
  logic [SEL_WIDTH-1:0]                sel_in;
  logic                                sel_load;
  logic                                blank_mode;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic                                s_axis_tvalid;
  logic [DATA_WIDTH-1:0]               m_axis_tdata;
  logic                                m_axis_tvalid;
  logic [SEL_WIDTH-1:0]                sel_active;
  logic                                busy;
  logic                                sel_error;

  modport master (
    output sel_in, sel_load, blank_mode, s_axis_tdata, s_axis_tvalid,
    input  m_axis_tdata, m_axis_tvalid, sel_active, busy, sel_error
  );

  modport slave (
    input  sel_in, sel_load, blank_mode, s_axis_tdata, s_axis_tvalid,
    output m_axis_tdata, m_axis_tvalid, sel_active, busy, sel_error
  );
endinterface

// File: rtl/signal_switch_n.sv
// N-channel glitch-free signal switch.
// Routes one of CHANNEL_COUNT signed sample streams onto a registered output.
// A channel change first passes through a blanking window of BLANK_BEATS valid
// samples. During that window the output is either held or forced to zero, so
// the downstream filters never see a step between two unrelated sources.
module signal_switch_n #(
  parameter int DATA_WIDTH    = 16,
  parameter int CHANNEL_COUNT = 4,
  parameter int SEL_WIDTH     = 2,
  parameter int BLANK_BEATS   = 8
) (
  input  logic             aclk,
  input  logic             areset,
  signal_switch_n_if.slave bus
);

  localparam int CNT_W = $clog2(BLANK_BEATS + 1);
  localparam int LIM_W = SEL_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLANK_BEATS - 1);
  localparam logic [LIM_W-1:0] CH_LIMIT  = LIM_W'(CHANNEL_COUNT);

  typedef enum logic {
    PASS  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SEL_WIDTH-1:0]  pending_q, pending_d;
  logic [SEL_WIDTH-1:0]  active_q, active_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q;
  logic                  error_q, error_d;

  logic                  selInRange;
  logic                  loadOk;
  logic [DATA_WIDTH-1:0] chanData;

  // Pick the sample of the currently routed channel out of the packed input bus
  always_comb begin
    chanData = '0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      if (active_q == SEL_WIDTH'(k)) begin
        chanData = bus.s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign selInRange = ({1'b0, bus.sel_in} < CH_LIMIT);
  assign loadOk     = bus.sel_load && selInRange;

  // Next-state logic: route in PASS, count blanked beats in BLANK; a reload restarts the window
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    active_d  = active_q;
    data_d    = data_q;
    error_d   = error_q;

    if (bus.sel_load && !selInRange) begin
      error_d = 1'b1;
    end

    case (state_q)
      PASS: begin
        if (bus.s_axis_tvalid) begin
          data_d = chanData;
        end
        if (loadOk && (bus.sel_in != active_q)) begin
          pending_d = bus.sel_in;
          count_d   = '0;
          state_d   = BLANK;
        end
      end
      BLANK: begin
        if (bus.s_axis_tvalid) begin
          if (bus.blank_mode) begin
            data_d = '0;
          end
          count_d = count_q + CNT_W'(1);
        end
        if (loadOk) begin
          pending_d = bus.sel_in;
          count_d   = '0;
        end else if (bus.s_axis_tvalid && (count_q == LAST_BEAT)) begin
          active_d = pending_q;
          count_d  = '0;
          state_d  = PASS;
        end
      end
      default: begin
        state_d = PASS;
      end
    endcase
  end

  // State and output registers; reset returns to PASS on channel 0 and clears the sticky error
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= PASS;
      count_q   <= '0;
      pending_q <= '0;
      active_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      data_q    <= data_d;
      valid_q   <= bus.s_axis_tvalid;
      error_q   <= error_d;
    end
  end

  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tvalid = valid_q;
  assign bus.sel_active    = active_q;
  assign bus.busy          = (state_q == BLANK);
  assign bus.sel_error     = error_q;

endmodule
